// File: rtl/spi_slave_cmd_ctrl.sv
// spi_slave_cmd_ctrl: command-decoding SPI mode-0 slave, fully sequenced in the clk_12MHz domain.
// Ports: clk_12MHz/i_rst system clock and async reset; i_SPI_CLK/i_SPI_CS/i_SPI_MOSI/o_SPI_MISO SPI pins;
// i_tx_frame/o_tx_frame_ack read-frame snapshot; o_wr_data/o_wr_valid write bytes; o_cmd/o_busy/o_err status.
module spi_slave_cmd_ctrl #(
    parameter int         FRAME_BYTES = 5,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_FILL   = 8'hFF
) (
    input  logic                     clk_12MHz,
    input  logic                     i_rst,
    input  logic                     i_SPI_CLK,
    input  logic                     i_SPI_CS,
    input  logic                     i_SPI_MOSI,
    output logic                     o_SPI_MISO,
    input  logic [8*FRAME_BYTES-1:0] i_tx_frame,
    output logic                     o_tx_frame_ack,
    output logic [7:0]               o_wr_data,
    output logic                     o_wr_valid,
    output logic [7:0]               o_cmd,
    output logic                     o_busy,
    output logic                     o_err
);
    localparam int W = 8 * FRAME_BYTES;

    typedef enum logic [2:0] {IDLE, CMD, READ, WRITE, DRAIN} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sck_s, cs_s, mosi_s;
    logic                   sck_d, cs_d;
    logic                   cs_low, cs_rise, cs_fall, rx_edge, tx_edge;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx_sh;
    logic                   byte_done;
    logic [4:0]             rd_cnt, rd_total;
    logic [W-1:0]           tx_sr;
    logic                   load, wr_stb, err_stb;

    // CS chain resets low so a CS already held low after reset never looks like a fresh fall
    always_ff @(posedge clk_12MHz or posedge i_rst) begin
        if (i_rst) begin
            sck_s  <= '0;
            cs_s   <= '0;
            mosi_s <= '0;
            sck_d  <= 1'b0;
            cs_d   <= 1'b0;
        end else begin
            sck_s  <= {sck_s[SYNC_STAGES-2:0], i_SPI_CLK};
            cs_s   <= {cs_s[SYNC_STAGES-2:0], i_SPI_CS};
            mosi_s <= {mosi_s[SYNC_STAGES-2:0], i_SPI_MOSI};
            sck_d  <= sck_s[SYNC_STAGES-1];
            cs_d   <= cs_s[SYNC_STAGES-1];
        end
    end

    assign cs_low   = ~cs_s[SYNC_STAGES-1];
    assign cs_rise  = cs_s[SYNC_STAGES-1] & ~cs_d;
    assign cs_fall  = cs_low & cs_d;
    assign rx_edge  = (state != IDLE) & cs_low & sck_s[SYNC_STAGES-1] & ~sck_d;
    assign tx_edge  = (state != IDLE) & cs_low & ~sck_s[SYNC_STAGES-1] & sck_d;
    assign rd_total = rd_cnt + {4'd0, byte_done};
    assign o_busy   = state != IDLE;
    assign o_tx_frame_ack = load;

    always_comb begin
        state_n = state;
        load    = 1'b0;
        wr_stb  = 1'b0;
        err_stb = 1'b0;
        case (state)
            IDLE:  state_n = cs_fall ? CMD : IDLE;
            CMD: if (byte_done) begin
                case (rx_sh)
                    8'h00: state_n = DRAIN;
                    8'h01: begin state_n = READ; load = 1'b1; end
                    8'h02: state_n = WRITE;
                    default: begin state_n = DRAIN; err_stb = 1'b1; end
                endcase
            end
            WRITE: wr_stb = byte_done;
            default: ;
        endcase
        // a byte completing alongside CS rise is handled above before returning to IDLE
        if (cs_rise && state != IDLE) begin
            state_n = IDLE;
            if (load || (state == READ && rd_total < 5'(FRAME_BYTES)))
                err_stb = 1'b1;
        end
    end

    always_ff @(posedge clk_12MHz or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_sh      <= '0;
            byte_done  <= 1'b0;
            rd_cnt     <= '0;
            tx_sr      <= '0;
            o_SPI_MISO <= IDLE_FILL[7];
            o_cmd      <= '0;
            o_wr_data  <= '0;
            o_wr_valid <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= (cs_rise || cs_fall) ? 3'd0 : rx_edge ? bit_cnt + 3'd1 : bit_cnt;
            rx_sh      <= rx_edge ? {rx_sh[6:0], mosi_s[SYNC_STAGES-1]} : rx_sh;
            byte_done  <= rx_edge && bit_cnt == 3'd7;
            rd_cnt     <= load ? 5'd0 : (state == READ && byte_done && rd_cnt < 5'(FRAME_BYTES)) ? rd_cnt + 5'd1 : rd_cnt;
            // fill bits shifted in behind the frame come out byte-aligned once the frame is exhausted
            tx_sr      <= load ? i_tx_frame : (tx_edge && state == READ) ? {tx_sr[W-2:0], IDLE_FILL[~bit_cnt]} : tx_sr;
            o_SPI_MISO <= cs_rise ? IDLE_FILL[7] : !tx_edge ? o_SPI_MISO : state == READ ? tx_sr[W-1] : IDLE_FILL[~bit_cnt];
            o_cmd      <= (state == CMD && byte_done) ? rx_sh : o_cmd;
            o_wr_data  <= wr_stb ? rx_sh : o_wr_data;
            o_wr_valid <= wr_stb;
            o_err      <= err_stb;
        end
    end
endmodule

// File: tb/tb_spi_slave_cmd_ctrl.sv
// tb_spi_slave_cmd_ctrl: self-checking bench for spi_slave_cmd_ctrl with write-byte and MISO scoreboards.
module tb_spi_slave_cmd_ctrl;
    logic        clk = 1'b0, rst = 1'b1, sck = 1'b0, cs = 1'b1, mosi = 1'b0;
    logic [39:0] frame = '0;
    logic        miso, ack, wr_valid, busy, err;
    logic [7:0]  wr_data, cmd;
    int          pass_cnt = 0, total_cnt = 0;
    int          cyc = 0, rise_cyc = 0, ack_cnt = 0, err_cnt = 0, wr_cnt = 0;
    logic [7:0]  wr_q[$];
    logic [7:0]  miso_q[$];

    spi_slave_cmd_ctrl dut (
        .clk_12MHz(clk), .i_rst(rst), .i_SPI_CLK(sck), .i_SPI_CS(cs), .i_SPI_MOSI(mosi),
        .o_SPI_MISO(miso), .i_tx_frame(frame), .o_tx_frame_ack(ack), .o_wr_data(wr_data),
        .o_wr_valid(wr_valid), .o_cmd(cmd), .o_busy(busy), .o_err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (ack) ack_cnt++;
            if (err) err_cnt++;
            if (wr_valid) begin
                wr_cnt++;
                total_cnt++;
                if (wr_q.size() == 0)
                    $display("FAIL wr_unexpected: got wr_data=%h, no write expected", wr_data);
                else begin
                    logic [7:0] exp_b;
                    exp_b = wr_q.pop_front();
                    if (wr_data !== exp_b) $display("FAIL wr_data: got %h, expected %h", wr_data, exp_b);
                    else pass_cnt++;
                end
                total_cnt++;
                if (cyc - rise_cyc !== 4) $display("FAIL wr_latency: got %0d clk, expected 4", cyc - rise_cyc);
                else pass_cnt++;
            end
        end
    end

    task automatic spi_xfer(input logic [7:0] d, input int n, output logic [7:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            mosi = d[7-i];
            repeat (8) @(negedge clk);
            r = {r[6:0], miso};
            sck = 1'b1;
            rise_cyc = cyc;
            repeat (8) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic cs_begin();
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_end();
        cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        total_cnt++; if (miso !== 1'b1) $display("FAIL reset_miso: got %b, expected 1", miso); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy); else pass_cnt++;
        total_cnt++; if (cmd !== 8'h00) $display("FAIL reset_cmd: got %h, expected 00", cmd); else pass_cnt++;
        total_cnt++; if ({ack, err, wr_valid} !== 3'b000) $display("FAIL reset_pulses: got %b, expected 000", {ack, err, wr_valid}); else pass_cnt++;
    endtask

    task automatic test_read();
        logic [7:0] r;
        int a0, e0;
        a0 = ack_cnt; e0 = err_cnt;
        frame = 40'h5925A2B012;
        miso_q.push_back(8'h59); miso_q.push_back(8'h25); miso_q.push_back(8'hA2);
        miso_q.push_back(8'hB0); miso_q.push_back(8'h12); miso_q.push_back(8'hFF);
        cs_begin();
        spi_xfer(8'h01, 8, r);
        total_cnt++; if (r !== 8'hFF) $display("FAIL read_cmd_miso: got %h, expected FF", r); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL read_busy: got %b, expected 1", busy); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            logic [7:0] exp_b;
            spi_xfer(8'h00, 8, r);
            exp_b = miso_q.pop_front();
            total_cnt++; if (r !== exp_b) $display("FAIL read_byte%0d: got %h, expected %h", i, r, exp_b); else pass_cnt++;
        end
        cs_end();
        total_cnt++; if (ack_cnt - a0 !== 1) $display("FAIL read_ack: got %0d pulses, expected 1", ack_cnt - a0); else pass_cnt++;
        total_cnt++; if (err_cnt - e0 !== 0) $display("FAIL read_err: got %0d pulses, expected 0", err_cnt - e0); else pass_cnt++;
        total_cnt++; if (cmd !== 8'h01) $display("FAIL read_cmd: got %h, expected 01", cmd); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL read_idle: got %b, expected 0", busy); else pass_cnt++;
    endtask

    task automatic test_write();
        logic [7:0] r;
        int e0, a0;
        e0 = err_cnt; a0 = ack_cnt;
        cs_begin();
        spi_xfer(8'h02, 8, r);
        wr_q.push_back(8'hAB);
        spi_xfer(8'hAB, 8, r);
        wr_q.push_back(8'hCD);
        spi_xfer(8'hCD, 8, r);
        cs_end();
        total_cnt++; if (wr_q.size() !== 0) $display("FAIL write_pending: got %0d outstanding, expected 0", wr_q.size()); else pass_cnt++;
        total_cnt++; if (cmd !== 8'h02) $display("FAIL write_cmd: got %h, expected 02", cmd); else pass_cnt++;
        total_cnt++; if ({err_cnt - e0, ack_cnt - a0} !== {32'd0, 32'd0}) $display("FAIL write_pulses: got err=%0d ack=%0d, expected 0 0", err_cnt - e0, ack_cnt - a0); else pass_cnt++;
    endtask

    task automatic test_bad_cmd();
        logic [7:0] r;
        int e0;
        e0 = err_cnt;
        cs_begin();
        spi_xfer(8'h7E, 8, r);
        total_cnt++; if (err_cnt - e0 !== 1) $display("FAIL bad_err: got %0d pulses, expected 1", err_cnt - e0); else pass_cnt++;
        total_cnt++; if (cmd !== 8'h7E) $display("FAIL bad_cmd: got %h, expected 7E", cmd); else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            spi_xfer(8'h96, 8, r);
            total_cnt++; if (r !== 8'hFF) $display("FAIL bad_miso%0d: got %h, expected FF", i, r); else pass_cnt++;
        end
        cs_end();
        total_cnt++; if (err_cnt - e0 !== 1) $display("FAIL bad_err_end: got %0d pulses, expected 1", err_cnt - e0); else pass_cnt++;
    endtask

    task automatic test_truncated_read();
        logic [7:0] r;
        int e0;
        e0 = err_cnt;
        frame = 40'hC33C9669A5;
        miso_q.push_back(8'hC3); miso_q.push_back(8'h3C);
        cs_begin();
        spi_xfer(8'h01, 8, r);
        for (int i = 0; i < 2; i++) begin
            logic [7:0] exp_b;
            spi_xfer(8'h00, 8, r);
            exp_b = miso_q.pop_front();
            total_cnt++; if (r !== exp_b) $display("FAIL trunc_byte%0d: got %h, expected %h", i, r, exp_b); else pass_cnt++;
        end
        cs_end();
        total_cnt++; if (err_cnt - e0 !== 1) $display("FAIL trunc_err: got %0d pulses, expected 1", err_cnt - e0); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL trunc_idle: got %b, expected 0", busy); else pass_cnt++;
        cs_begin();
        spi_xfer(8'h02, 8, r);
        wr_q.push_back(8'h55);
        spi_xfer(8'h55, 8, r);
        cs_end();
        total_cnt++; if (wr_q.size() !== 0) $display("FAIL trunc_write: got %0d outstanding, expected 0", wr_q.size()); else pass_cnt++;
        total_cnt++; if (wr_data !== 8'h55) $display("FAIL trunc_wr_data: got %h, expected 55", wr_data); else pass_cnt++;
    endtask

    task automatic test_partial_and_reset();
        logic [7:0] r;
        int w0;
        w0 = wr_cnt;
        cs_begin();
        spi_xfer(8'h02, 8, r);
        spi_xfer(8'hF0, 4, r);
        cs_end();
        total_cnt++; if (wr_cnt - w0 !== 0) $display("FAIL partial_wr: got %0d writes, expected 0", wr_cnt - w0); else pass_cnt++;
        cs_begin();
        spi_xfer(8'h02, 8, r);
        spi_xfer(8'hA0, 3, r);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, expected 0", busy); else pass_cnt++;
        total_cnt++; if (cmd !== 8'h00) $display("FAIL rst_cmd: got %h, expected 00", cmd); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        spi_xfer(8'h5A, 5, r);
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_ignore: got busy %b, expected 0", busy); else pass_cnt++;
        cs_end();
        total_cnt++; if (wr_cnt - w0 !== 0) $display("FAIL rst_wr: got %0d writes, expected 0", wr_cnt - w0); else pass_cnt++;
        cs_begin();
        spi_xfer(8'h02, 8, r);
        wr_q.push_back(8'h3C);
        spi_xfer(8'h3C, 8, r);
        cs_end();
        total_cnt++; if (wr_cnt - w0 !== 1) $display("FAIL recover_wr: got %0d writes, expected 1", wr_cnt - w0); else pass_cnt++;
        total_cnt++; if (wr_q.size() !== 0) $display("FAIL recover_pending: got %0d outstanding, expected 0", wr_q.size()); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_bad_cmd();
        test_truncated_read();
        test_partial_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/spi_slave_cmd_ctrl.md
Name: spi_slave_cmd_ctrl

Overview:
Command-driven SPI slave controller in the clk_12MHz domain. Oversamples SPI pins through synchronizers, decodes the first byte of each CS-low transaction as a command, then sequences the MISO datapath: a FRAME_BYTES snapshot for reads, byte strobes for writes. Sits between the external SPI master and the on-chip data producer/consumer; replaces ad-hoc SCK-domain shifting with one-clock-domain sequencing.

Parameters:
FRAME_BYTES, 5, number of bytes returned by READ_FRAME (1..16)
SYNC_STAGES, 2, synchronizer depth on SCK/CS/MOSI (>=2)
IDLE_FILL, 8'hFF, byte shifted on MISO when no data is scheduled

Ports:
clk_12MHz  input  1  system clock
i_rst  input  1  asynchronous reset, active high
i_SPI_CLK  input  1  SPI clock from master, mode 0, SCK <= clk/8
i_SPI_CS  input  1  chip select, active low
i_SPI_MOSI  input  1  master-out data, MSB first
o_SPI_MISO  output  1  slave-out data, MSB first, always driven
i_tx_frame  input  8*FRAME_BYTES  frame to return; byte 0 = [MSB:MSB-7], sent first
o_tx_frame_ack  output  1  1-cycle pulse when i_tx_frame is snapshotted
o_wr_data  output  8  received write byte
o_wr_valid  output  1  1-cycle pulse, o_wr_data valid
o_cmd  output  8  last decoded command byte, held until next command
o_busy  output  1  high while in any state other than IDLE
o_err  output  1  1-cycle pulse on unknown command or truncated read

Behaviour:
- Reset (async assert, sync release): state IDLE; o_SPI_MISO=IDLE_FILL[7]; o_cmd=0; o_wr_data=0; all pulses/o_busy=0; bit and byte counters 0.
- Sync: SCK, CS, MOSI each through SYNC_STAGES flops; rise/fall detected on SCK sync output vs. one extra flop. MOSI sampled on detected SCK rise; MISO updated on detected SCK fall. Only detected edges with CS_sync low count.
- Bit counter 3 bits, wraps 7->0; byte completes on 8th sampled rise.
- States: IDLE -> CMD on CS_sync fall. CMD: on byte complete decode: 8'h00 NOP -> DRAIN; 8'h01 READ_FRAME -> READ; 8'h02 WRITE -> WRITE; other -> DRAIN + o_err pulse. o_cmd updated at decode for all values.
- CMD: MISO shifts IDLE_FILL.
- READ: on cmd decode cycle snapshot i_tx_frame into shift register, pulse o_tx_frame_ack same cycle; first frame bit appears on MISO at the next SCK fall (mode 0 timing). After FRAME_BYTES bytes shifted, MISO shifts IDLE_FILL repeatedly; state stays READ until CS high.
- WRITE: each completed byte -> o_wr_data, o_wr_valid pulse in the cycle after the completing rise is detected; unlimited bytes.
- DRAIN: ignore MOSI, MISO = IDLE_FILL, until CS high.
- CS_sync rise in any state: -> IDLE next cycle, bit counter cleared, partial byte discarded (no wr_valid). If in READ with fewer than FRAME_BYTES bytes completed -> o_err pulse. MISO reloads IDLE_FILL[7].
- CS rise and byte completion in the same cycle: completion processed first (wr_valid/decode), then IDLE.
- Latency: o_wr_valid asserts SYNC_STAGES+2 clk after the 8th SCK rising edge at the pin.
- i_rst mid-transaction: immediate IDLE; remaining SCK edges ignored until a fresh CS fall.

Test Plan:
- Reset with CS high -> o_SPI_MISO=1, o_busy=0, o_cmd=0, no pulses.
- CS low, MOSI 8'h01, i_tx_frame=40'h5925A2B012, 40 more SCK -> o_tx_frame_ack once, MISO bytes 59 25 A2 B0 12, then 8 more SCK -> FF, o_err=0.
- CS low, MOSI 02 AB CD, CS high -> o_wr_valid twice with o_wr_data AB then CD, o_cmd=02.
- CS low, MOSI 8'h7E -> o_err one pulse, o_cmd=7E, MISO stays 1 through 16 further SCK.
- READ_FRAME, CS high after 2 response bytes -> o_err pulse, state IDLE; next WRITE transaction 02 55 -> o_wr_data=55.
- WRITE 02 then 4 bits of data, CS high -> no o_wr_valid; i_rst pulsed mid-byte in new transaction -> o_busy=0 within 1 clk.
